// File: rtl/mux_nx1_rr_reg_if.sv
// Handshake bundle for mux_nx1_rr_reg: N producer channels in, one registered beat out.
// The slave modport is the mux side; the master modport is the producer/consumer side.
interface mux_nx1_rr_reg_if #(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 1,
    parameter int SEL_W  = $clog2(NUM_CH)
);
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_nx1_rr_reg.sv
// N-to-1 mux with a one-entry registered output, fixed-select or round-robin grant.
// Define MUX_BEAT_CNT_EN to add the saturating 16-bit accepted-beat counter port beat_cnt.
module mux_nx1_rr_reg #(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 1,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    mux_nx1_rr_reg_if.slave     bus
`ifdef MUX_BEAT_CNT_EN
    ,
    output logic [15:0]         beat_cnt
`endif
);

    logic [WIDTH-1:0]  out_data_r;
    logic [SEL_W-1:0]  out_ch_r;
    logic              out_valid_r;
    logic [SEL_W-1:0]  ptr_r;

    logic              load_en_s;
    logic              gnt_found_s;
    logic [SEL_W-1:0]  gnt_idx_s;
    logic              hs_s;
    logic [NUM_CH-1:0] in_ready_s;
    logic [SEL_W-1:0]  ptr_next_s;

    assign load_en_s  = !out_valid_r || bus.out_ready;
    assign hs_s       = gnt_found_s && load_en_s && !rst;
    assign ptr_next_s = (gnt_idx_s == SEL_W'(NUM_CH - 1)) ? {SEL_W{1'b0}} : gnt_idx_s + SEL_W'(1);

    // Grant selection: exact sel match in fixed mode, first valid from ptr with wrap in round-robin.
    always_comb begin
        int  idx_v;
        logic hit_v;
        gnt_found_s = 1'b0;
        gnt_idx_s   = {SEL_W{1'b0}};
        idx_v       = 0;
        hit_v       = 1'b0;
        if (bus.mode == 1'b0) begin
            // sel values at or above NUM_CH match no k, so they never grant.
            for (int k = 0; k < NUM_CH; k++) begin
                hit_v       = (SEL_W'(k) == bus.sel) && bus.in_valid[k];
                gnt_idx_s   = hit_v ? SEL_W'(k) : gnt_idx_s;
                gnt_found_s = gnt_found_s || hit_v;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx_v       = int'(ptr_r) + k;
                idx_v       = (idx_v >= NUM_CH) ? idx_v - NUM_CH : idx_v;
                hit_v       = !gnt_found_s && bus.in_valid[idx_v];
                gnt_idx_s   = hit_v ? SEL_W'(idx_v) : gnt_idx_s;
                gnt_found_s = gnt_found_s || hit_v;
            end
        end
    end

    // One-hot ready toward the granted channel only.
    always_comb begin
        in_ready_s            = {NUM_CH{1'b0}};
        in_ready_s[gnt_idx_s] = hs_s;
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_ch    = out_ch_r;
    assign bus.out_valid = out_valid_r;

    // Output buffer and round-robin pointer; a drain without a new grant empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r  <= {WIDTH{1'b0}};
            out_ch_r    <= {SEL_W{1'b0}};
            out_valid_r <= 1'b0;
            ptr_r       <= {SEL_W{1'b0}};
        end else if (hs_s) begin
            out_data_r  <= bus.in_data[int'(gnt_idx_s)*WIDTH +: WIDTH];
            out_ch_r    <= gnt_idx_s;
            out_valid_r <= 1'b1;
            ptr_r       <= bus.mode ? ptr_next_s : ptr_r;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef MUX_BEAT_CNT_EN
    logic [15:0] beat_cnt_r;

    // Saturating count of accepted input beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_r <= 16'h0000;
        end else if (hs_s && (beat_cnt_r != 16'hFFFF)) begin
            beat_cnt_r <= beat_cnt_r + 16'h0001;
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    assign beat_cnt = beat_cnt_r;
`endif

endmodule

// File: tb/tb_mux_nx1_rr_reg.sv
// Self-checking bench for mux_nx1_rr_reg (NUM_CH=8, WIDTH=4): directed scenarios plus
// randomized traffic compared against a transaction-level model of the grant rules.
module tb_mux_nx1_rr_reg;
    localparam int N = 8;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_nx1_rr_reg_if #(.NUM_CH(N), .WIDTH(W)) bus ();
`ifdef MUX_BEAT_CNT_EN
    logic [15:0] beat_cnt;
`endif

    mux_nx1_rr_reg #(.NUM_CH(N), .WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef MUX_BEAT_CNT_EN
        ,
        .beat_cnt (beat_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model of the output buffer and round-robin pointer.
    bit         m_valid = 1'b0;
    logic [3:0] m_data  = 4'h0;
    int         m_ch    = 0;
    int         m_ptr   = 0;

    // Expected ready vector: the channel closest after ptr (circular distance) or the sel channel.
    function automatic logic [7:0] exp_ready();
        int best = N;
        int g = 0;
        if (rst) return 8'h00;
        if (m_valid && !bus.out_ready) return 8'h00;
        if (!bus.mode) return bus.in_valid[bus.sel] ? (8'h01 << bus.sel) : 8'h00;
        for (int k = 0; k < N; k++) begin
            if (bus.in_valid[k] && (((k - m_ptr + N) % N) < best)) begin
                best = (k - m_ptr + N) % N;
                g = k;
            end
        end
        return (best < N) ? (8'h01 << g) : 8'h00;
    endfunction

    task automatic tick();
        logic [7:0] r;
        int g;
        r = exp_ready();
        g = -1;
        for (int k = 0; k < N; k++) if (r[k]) g = k;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = 4'h0; m_ch = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_data  = bus.in_data[g*W +: W];
            m_ch    = g;
            m_valid = 1'b1;
            if (bus.mode) m_ptr = (g + 1) % N;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic set_data_k3();
        for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = 4'(k + 3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 8'hFF; bus.mode = 1'b1; bus.sel = 3'd0; bus.out_ready = 1'b1;
        set_data_k3();
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (bus.in_ready !== 8'h00) begin
                errors++; $display("FAIL reset_in_ready: got %h expected 00", bus.in_ready);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.out_ch !== 3'd0) begin
                errors++;
                $display("FAIL reset_outputs: got valid=%b data=%h ch=%0d expected 0/0/0",
                         bus.out_valid, bus.out_data, bus.out_ch);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 8'h01) begin
            errors++; $display("FAIL post_reset_ready: got %h expected 01", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 3'd0 || bus.out_data !== 4'h3) begin
            errors++;
            $display("FAIL first_beat: got valid=%b data=%h ch=%0d expected 1/3/0",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
    endtask

    task automatic test_fixed_sweep();
        bus.mode = 1'b0; bus.in_valid = 8'hFF; bus.out_ready = 1'b1;
        set_data_k3();
        for (int s = 0; s < N; s++) begin
            bus.sel = 3'(s);
            #1;
            checks++;
            if (bus.in_ready !== (8'h01 << s)) begin
                errors++; $display("FAIL fixed_ready sel=%0d: got %h expected %h", s, bus.in_ready, 8'h01 << s);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_ch !== 3'(s) || bus.out_data !== 4'(s + 3)) begin
                errors++;
                $display("FAIL fixed_beat sel=%0d: got valid=%b data=%h ch=%0d expected 1/%h/%0d",
                         s, bus.out_valid, bus.out_data, bus.out_ch, 4'(s + 3), s);
            end
        end
        bus.sel = 3'd0; bus.in_valid = 8'hFE;
        #1;
        checks++;
        if (bus.in_ready !== 8'h00) begin
            errors++; $display("FAIL fixed_invalid_sel: got %h expected 00", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_ch !== 3'd7 || bus.out_data !== 4'hA) begin
            errors++;
            $display("FAIL fixed_drain: got valid=%b data=%h ch=%0d expected 0/a/7",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
    endtask

    task automatic test_rr_fairness();
        int seq[4] = '{0, 2, 5, 7};
        do_reset();
        bus.mode = 1'b1; bus.in_valid = 8'b1010_0101; bus.out_ready = 1'b1;
        for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = 4'(15 - k);
        for (int i = 0; i < 12; i++) begin
            #1;
            checks++;
            if (bus.in_ready !== (8'h01 << seq[i % 4])) begin
                errors++; $display("FAIL rr_ready step %0d: got %h expected %h", i, bus.in_ready, 8'h01 << seq[i % 4]);
            end
            tick();
            checks++;
            if (bus.out_ch !== 3'(seq[i % 4]) || bus.out_data !== 4'(15 - seq[i % 4]) || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_beat step %0d: got ch=%0d data=%h expected ch=%0d data=%h",
                         i, bus.out_ch, bus.out_data, seq[i % 4], 4'(15 - seq[i % 4]));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.mode = 1'b1; bus.in_valid = 8'hFF; bus.out_ready = 1'b1;
        set_data_k3();
        tick();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (bus.in_ready !== 8'h00) begin
                errors++; $display("FAIL stall_ready cycle %0d: got %h expected 00", c, bus.in_ready);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_ch !== 3'd0 || bus.out_data !== 4'h3) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got valid=%b data=%h ch=%0d expected 1/3/0",
                         c, bus.out_valid, bus.out_data, bus.out_ch);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 8'h02) begin
            errors++; $display("FAIL release_ready: got %h expected 02", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 3'd1 || bus.out_data !== 4'h4) begin
            errors++;
            $display("FAIL release_beat: got valid=%b data=%h ch=%0d expected 1/4/1",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
    endtask

    task automatic test_wrap_drain();
        do_reset();
        bus.mode = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 8'h40;
        set_data_k3();
        tick();
        bus.in_valid = 8'h02;
        #1;
        checks++;
        if (bus.in_ready !== 8'h02) begin
            errors++; $display("FAIL wrap_ready: got %h expected 02", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_ch !== 3'd1 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_beat: got ch=%0d valid=%b expected 1/1", bus.out_ch, bus.out_valid);
        end
        bus.in_valid = 8'h00;
        #1;
        checks++;
        if (bus.in_ready !== 8'h00) begin
            errors++; $display("FAIL idle_ready: got %h expected 00", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_ch !== 3'd1 || bus.out_data !== 4'h4) begin
            errors++;
            $display("FAIL drain_empty: got valid=%b data=%h ch=%0d expected 0/4/1",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
        bus.in_valid = 8'h0F;
        #1;
        checks++;
        if (bus.in_ready !== 8'h04) begin
            errors++; $display("FAIL ptr_after_wrap: got %h expected 04", bus.in_ready);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst           = ($urandom_range(0, 39) == 0);
            bus.mode      = 1'($urandom_range(0, 1));
            bus.sel       = 3'($urandom_range(0, 7));
            bus.in_valid  = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_data   = 32'($urandom);
            #1;
            checks++;
            if (bus.in_ready !== exp_ready()) begin
                errors++; $display("FAIL rand_ready cycle %0d: got %h expected %h", c, bus.in_ready, exp_ready());
            end
            tick();
            checks++;
            if (bus.out_valid !== m_valid || bus.out_data !== m_data || bus.out_ch !== 3'(m_ch)) begin
                errors++;
                $display("FAIL rand_out cycle %0d: got valid=%b data=%h ch=%0d expected %b/%h/%0d",
                         c, bus.out_valid, bus.out_data, bus.out_ch, m_valid, m_data, m_ch);
            end
        end
        rst = 1'b0;
    endtask

`ifdef MUX_BEAT_CNT_EN
    task automatic test_beat_cnt();
        do_reset();
        bus.mode = 1'b1; bus.in_valid = 8'hFF; bus.out_ready = 1'b1;
        #1;
        checks++;
        if (beat_cnt !== 16'h0000) begin
            errors++; $display("FAIL cnt_reset: got %h expected 0000", beat_cnt);
        end
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (beat_cnt !== 16'd100) begin
            errors++; $display("FAIL cnt_100: got %0d expected 100", beat_cnt);
        end
        repeat (69900) @(posedge clk);
        #1;
        checks++;
        if (beat_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL cnt_saturate: got %h expected ffff", beat_cnt);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (beat_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL cnt_hold: got %h expected ffff", beat_cnt);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (beat_cnt !== 16'h0000) begin
            errors++; $display("FAIL cnt_rst: got %h expected 0000", beat_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fixed_sweep();
        test_rr_fairness();
        test_backpressure();
        test_wrap_drain();
        test_random();
`ifdef MUX_BEAT_CNT_EN
        test_beat_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
